pipe_ctrl_hazard_unit: RTL and testbench
========================================

// Module: pipe_ctrl_hazard_unit
// PURPOSE
//  Consumer end of the decoder control word: carries Branch/MemRead/MemtoReg/ALUOp/MemWrite/ALUSrc/
//  RegWrite/Jump from ID through the EX, MEM and WB stage registers of the 5-stage RV32I pipeline.
//  Detects load-use hazards (stall + bubble) and EX-resolved branch/jump redirects (flush).
//  Produces the EX operand forwarding selects. It sits between the control decoder and the datapath stage registers.
// PARAMETERS
//  REG_ADDR_W  5  register index width
//  ALUOP_W     2  ALUOp width
// PORTS
//  clk              in   1          rising-edge clock
//  rst_n            in   1          asynchronous, active-low reset
//  id_valid         in   1          ID holds a live instruction
//  id_rs1/id_rs2/id_rd in REG_ADDR_W  ID register fields
//  id_branch,id_mem_read,id_memto_reg,id_mem_write,id_alu_src,id_reg_write,id_jump in 1  decoder outputs
//  id_alu_op        in   ALUOP_W    decoder ALUOp
//  ex_branch_cond   in   1          ALU comparison result for the instruction in EX
//  pc_write_en      out  1          0 = hold PC
//  if_id_write_en   out  1          0 = hold IF/ID register
//  if_id_flush      out  1          1 = IF/ID loads a bubble
//  ex_alu_op        out  ALUOP_W    EX controls: ALU operation
//  ex_alu_src       out  1          EX controls: ALU B-operand source select
//  ex_branch, ex_jump out 1         EX branch/jump controls
//  ex_redirect      out  1          PC takes branch/jump target
//  forward_a/forward_b out 2        00 regfile, 10 from MEM, 01 from WB
//  mem_mem_read, mem_mem_write out 1  MEM controls
//  wb_reg_write, wb_memto_reg  out 1  WB controls
//  wb_rd            out  REG_ADDR_W WB destination
// BEHAVIOUR
//  Reset: all stage valid bits and all control registers go to 0, and all *_rd go to 0.
//   Consequently: pc_write_en=1, if_id_write_en=1, if_id_flush=0, ex_redirect=0, forward_a/b=00.
//  Stage flow: each clock ID->EX->MEM->WB. A stage whose valid bit is 0 drives all its control outputs as 0.
//  ex_redirect is combinational: ex_valid & (ex_jump | (ex_branch & ex_branch_cond)).
//  load_use is combinational: id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
//   rs2 is compared for every format (conservative; spurious stalls are permitted).
//  Stall (load_use & !ex_redirect):
//   - pc_write_en=0 and if_id_write_en=0.
//   - EX loads a bubble (valid=0, controls 0).
//   - MEM and WB advance normally.
//   - The stall lasts exactly 1 cycle per load-use pair.
//  Redirect (ex_redirect):
//   - if_id_flush=1 and EX loads a bubble next cycle.
//   - pc_write_en=1 and if_id_write_en=1.
//   - The redirecting instruction itself advances to MEM; JAL/JALR keep reg_write for the link.
//   - Redirect has priority over stall: the stalled ID instruction is killed, and no stall is asserted.
//  Forwarding, per operand X in {a,b}, using ex_rsX. Combinational from registered state only:
//   - 10 if mem_valid & mem_reg_write & mem_rd!=0 & mem_rd==ex_rsX;
//   - else 01 if wb_valid & wb_reg_write & wb_rd!=0 & wb_rd==ex_rsX;
//   - else 00. MEM wins when both match.
//  x0 is never a hazard or forward source.
//  Reset asserted mid-stall or mid-flush: all state clears immediately (async). The first edge after release is a normal advance.
// STRUCTURE
//  Shared package: ALUOp encodings (00 add, 01 branch, 10 R, 11 I), FWD_RF/FWD_MEM/FWD_WB, RV32I opcode constants.
//  One sub-module: pipe_ctrl_stage_reg.
//   - Parametric-width valid+payload register with enable and bubble inputs.
//   - Instantiated for EX, MEM and WB.
//  Hazard and forward logic stay in the top level.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles -> pc_write_en=1, if_id_flush=0, forward_a/b=00, wb_reg_write=0.
//  2. Load-use: lw x5 in EX, add x6,x5,x1 in ID -> exactly one cycle with pc_write_en=0 and EX bubble. Next cycle forward_a=01 (WB).
//  3. Back-to-back ALU: add x3 (now MEM) then sub x4,x3,x3 (now EX) -> forward_a=forward_b=10. With rd=x0 instead -> 00.
//  4. Double hazard: x7 written in both MEM and WB, ex_rs1=x7 -> forward_a=10.
//  5. Taken beq: ex_branch=1, ex_branch_cond=1 -> ex_redirect=1 and if_id_flush=1, next EX invalid. With cond=0 -> no flush.
//  6. Redirect and load_use in the same cycle -> flush asserted, pc_write_en=1, no stall cycle.
//     Then rst_n low mid-stall -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pipe_ctrl_hazard_unit_pkg.sv
// Shared encodings for the pipeline control / hazard unit: ALUOp values, forward selects
// and the RV32I major opcodes the control decoder keys on.
package pipe_ctrl_hazard_unit_pkg;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_I      = 2'b11;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

// File: rtl/pipe_ctrl_stage_reg.sv
// Valid + payload pipeline stage register. A bubble or an invalid input leaves the
// payload all-zero so downstream consumers never see stale controls.
module pipe_ctrl_stage_reg
    import pipe_ctrl_hazard_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_bubble,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= i_valid ? i_data : '0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_ctrl_hazard_unit.sv
// Carries decoder controls through EX/MEM/WB, detects load-use stalls and EX-resolved
// redirects, and produces the EX operand forwarding selects.
module pipe_ctrl_hazard_unit
    import pipe_ctrl_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUOP_W    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_branch,
    input  logic                  i_id_mem_read,
    input  logic                  i_id_memto_reg,
    input  logic                  i_id_mem_write,
    input  logic                  i_id_alu_src,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_jump,
    input  logic [ALUOP_W-1:0]    i_id_alu_op,
    input  logic                  i_ex_branch_cond,
    output logic                  o_pc_write_en,
    output logic                  o_if_id_write_en,
    output logic                  o_if_id_flush,
    output logic [ALUOP_W-1:0]    o_ex_alu_op,
    output logic                  o_ex_alu_src,
    output logic                  o_ex_branch,
    output logic                  o_ex_jump,
    output logic                  o_ex_redirect,
    output logic [1:0]            o_forward_a,
    output logic [1:0]            o_forward_b,
    output logic                  o_mem_mem_read,
    output logic                  o_mem_mem_write,
    output logic                  o_wb_reg_write,
    output logic                  o_wb_memto_reg,
    output logic [REG_ADDR_W-1:0] o_wb_rd
);

    localparam int unsigned EX_W  = 3 * REG_ADDR_W + ALUOP_W + 7;
    localparam int unsigned MEM_W = REG_ADDR_W + 4;
    localparam int unsigned WB_W  = REG_ADDR_W + 2;

    logic [EX_W-1:0]       w_ex_d, w_ex_q;
    logic [MEM_W-1:0]      w_mem_d, w_mem_q;
    logic [WB_W-1:0]       w_wb_d, w_wb_q;
    logic                  w_ex_valid, w_mem_valid, w_wb_valid;

    logic [REG_ADDR_W-1:0] w_ex_rs1, w_ex_rs2, w_ex_rd, w_mem_rd, w_wb_rd;
    logic [ALUOP_W-1:0]    w_ex_alu_op;
    logic                  w_ex_branch, w_ex_mem_read, w_ex_memto_reg, w_ex_mem_write;
    logic                  w_ex_alu_src, w_ex_reg_write, w_ex_jump;
    logic                  w_mem_mem_read, w_mem_memto_reg, w_mem_mem_write, w_mem_reg_write;
    logic                  w_wb_memto_reg, w_wb_reg_write;

    logic                  w_redirect, w_load_use, w_stall, w_ex_bubble;

    assign w_ex_d = {i_id_rs1, i_id_rs2, i_id_rd, i_id_alu_op, i_id_branch, i_id_mem_read,
                     i_id_memto_reg, i_id_mem_write, i_id_alu_src, i_id_reg_write, i_id_jump};
    assign {w_ex_rs1, w_ex_rs2, w_ex_rd, w_ex_alu_op, w_ex_branch, w_ex_mem_read,
            w_ex_memto_reg, w_ex_mem_write, w_ex_alu_src, w_ex_reg_write, w_ex_jump} = w_ex_q;

    assign w_mem_d = {w_ex_rd, w_ex_mem_read, w_ex_memto_reg, w_ex_mem_write, w_ex_reg_write};
    assign {w_mem_rd, w_mem_mem_read, w_mem_memto_reg, w_mem_mem_write, w_mem_reg_write} = w_mem_q;

    assign w_wb_d = {w_mem_rd, w_mem_memto_reg, w_mem_reg_write};
    assign {w_wb_rd, w_wb_memto_reg, w_wb_reg_write} = w_wb_q;

    assign w_redirect = w_ex_valid & (w_ex_jump | (w_ex_branch & i_ex_branch_cond));
    // rs2 is compared regardless of format; a spurious stall is harmless.
    assign w_load_use = i_id_valid & w_ex_valid & w_ex_mem_read & (w_ex_rd != '0) &
                        ((w_ex_rd == i_id_rs1) | (w_ex_rd == i_id_rs2));
    assign w_stall     = w_load_use & ~w_redirect;
    assign w_ex_bubble = w_stall | w_redirect;

    assign o_pc_write_en    = ~w_stall;
    assign o_if_id_write_en = ~w_stall;
    assign o_if_id_flush    = w_redirect;
    assign o_ex_redirect    = w_redirect;

    pipe_ctrl_stage_reg #(.WIDTH(EX_W)) u_ex_reg (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (1'b1),
        .i_bubble (w_ex_bubble),
        .i_valid  (i_id_valid),
        .i_data   (w_ex_d),
        .o_valid  (w_ex_valid),
        .o_data   (w_ex_q)
    );

    pipe_ctrl_stage_reg #(.WIDTH(MEM_W)) u_mem_reg (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (1'b1),
        .i_bubble (1'b0),
        .i_valid  (w_ex_valid),
        .i_data   (w_mem_d),
        .o_valid  (w_mem_valid),
        .o_data   (w_mem_q)
    );

    pipe_ctrl_stage_reg #(.WIDTH(WB_W)) u_wb_reg (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (1'b1),
        .i_bubble (1'b0),
        .i_valid  (w_mem_valid),
        .i_data   (w_wb_d),
        .o_valid  (w_wb_valid),
        .o_data   (w_wb_q)
    );

    assign o_ex_alu_op     = w_ex_valid ? w_ex_alu_op : '0;
    assign o_ex_alu_src    = w_ex_valid & w_ex_alu_src;
    assign o_ex_branch     = w_ex_valid & w_ex_branch;
    assign o_ex_jump       = w_ex_valid & w_ex_jump;
    assign o_mem_mem_read  = w_mem_valid & w_mem_mem_read;
    assign o_mem_mem_write = w_mem_valid & w_mem_mem_write;
    assign o_wb_reg_write  = w_wb_valid & w_wb_reg_write;
    assign o_wb_memto_reg  = w_wb_valid & w_wb_memto_reg;
    assign o_wb_rd         = w_wb_valid ? w_wb_rd : '0;

    // MEM has the younger result, so it wins over WB on a double match.
    always_comb begin
        o_forward_a = FWD_RF;
        if (w_mem_valid & w_mem_reg_write & (w_mem_rd != '0) & (w_mem_rd == w_ex_rs1)) begin
            o_forward_a = FWD_MEM;
        end else if (w_wb_valid & w_wb_reg_write & (w_wb_rd != '0) & (w_wb_rd == w_ex_rs1)) begin
            o_forward_a = FWD_WB;
        end
    end

    always_comb begin
        o_forward_b = FWD_RF;
        if (w_mem_valid & w_mem_reg_write & (w_mem_rd != '0) & (w_mem_rd == w_ex_rs2)) begin
            o_forward_b = FWD_MEM;
        end else if (w_wb_valid & w_wb_reg_write & (w_wb_rd != '0) & (w_wb_rd == w_ex_rs2)) begin
            o_forward_b = FWD_WB;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// Bench for pipe_ctrl_hazard_unit: directed scenarios plus random instruction streams
// checked against a slot-based pipeline model.
module tb_pipe_ctrl_hazard_unit;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       branch;
        logic       mem_read;
        logic       memto_reg;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
    } slot_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cond = 1'b0;
    slot_t id_s = '0;

    slot_t m_ex = '0, m_mem = '0, m_wb = '0;
    int n_checks = 0;
    int n_fail = 0;

    logic       pc_we, ifid_we, flush, ex_alu_src, ex_branch, ex_jump, redirect;
    logic       mem_mr, mem_mw, wb_rw, wb_mtr;
    logic [1:0] ex_alu_op, fwd_a, fwd_b;
    logic [4:0] wb_rd;

    always #5 clk = ~clk;

    pipe_ctrl_hazard_unit #(.REG_ADDR_W(5), .ALUOP_W(2)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_id_valid       (id_s.valid),
        .i_id_rs1         (id_s.rs1),
        .i_id_rs2         (id_s.rs2),
        .i_id_rd          (id_s.rd),
        .i_id_branch      (id_s.branch),
        .i_id_mem_read    (id_s.mem_read),
        .i_id_memto_reg   (id_s.memto_reg),
        .i_id_mem_write   (id_s.mem_write),
        .i_id_alu_src     (id_s.alu_src),
        .i_id_reg_write   (id_s.reg_write),
        .i_id_jump        (id_s.jump),
        .i_id_alu_op      (id_s.alu_op),
        .i_ex_branch_cond (cond),
        .o_pc_write_en    (pc_we),
        .o_if_id_write_en (ifid_we),
        .o_if_id_flush    (flush),
        .o_ex_alu_op      (ex_alu_op),
        .o_ex_alu_src     (ex_alu_src),
        .o_ex_branch      (ex_branch),
        .o_ex_jump        (ex_jump),
        .o_ex_redirect    (redirect),
        .o_forward_a      (fwd_a),
        .o_forward_b      (fwd_b),
        .o_mem_mem_read   (mem_mr),
        .o_mem_mem_write  (mem_mw),
        .o_wb_reg_write   (wb_rw),
        .o_wb_memto_reg   (wb_mtr),
        .o_wb_rd          (wb_rd)
    );

    // ---------------- reference model ----------------
    function automatic logic m_redirect();
        return m_ex.valid && (m_ex.jump || (m_ex.branch && cond));
    endfunction

    function automatic logic m_load_use();
        return id_s.valid && m_ex.valid && m_ex.mem_read && m_ex.rd != 0 &&
               (m_ex.rd == id_s.rs1 || m_ex.rd == id_s.rs2);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (rs != 0 && m_mem.valid && m_mem.reg_write && m_mem.rd == rs) return 2'b10;
        if (rs != 0 && m_wb.valid && m_wb.reg_write && m_wb.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [21:0] m_expect();
        logic stall;
        stall = m_load_use() && !m_redirect();
        return {!stall, !stall, m_redirect(), m_redirect(), m_fwd(m_ex.rs1), m_fwd(m_ex.rs2),
                m_ex.valid ? m_ex.alu_op : 2'b00, m_ex.valid & m_ex.alu_src,
                m_ex.valid & m_ex.branch, m_ex.valid & m_ex.jump,
                m_mem.valid & m_mem.mem_read, m_mem.valid & m_mem.mem_write,
                m_wb.valid & m_wb.reg_write, m_wb.valid & m_wb.memto_reg,
                m_wb.valid ? m_wb.rd : 5'd0};
    endfunction

    task automatic model_advance();
        logic kill;
        kill = !id_s.valid || m_redirect() || m_load_use();
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = kill ? slot_t'('0) : id_s;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_advance();
        @(negedge clk);
    endtask

    task automatic drain();
        id_s = '0;
        cond = 1'b0;
        repeat (3) tick();
    endtask

    // ---------------- instruction builders ----------------
    function automatic slot_t mk_alu(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
        slot_t s = '0;
        s.valid = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
        s.reg_write = 1'b1; s.alu_op = 2'b10;
        return s;
    endfunction

    function automatic slot_t mk_lw(input logic [4:0] rd, input logic [4:0] rs1);
        slot_t s = '0;
        s.valid = 1'b1; s.rd = rd; s.rs1 = rs1;
        s.mem_read = 1'b1; s.memto_reg = 1'b1; s.reg_write = 1'b1; s.alu_src = 1'b1;
        return s;
    endfunction

    function automatic slot_t mk_beq(input logic [4:0] rs1, input logic [4:0] rs2);
        slot_t s = '0;
        s.valid = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.branch = 1'b1; s.alu_op = 2'b01;
        return s;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL reset_pc_we got %b want 1", pc_we); end
        n_checks++; if (ifid_we !== 1'b1) begin n_fail++; $display("FAIL reset_ifid_we got %b want 1", ifid_we); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", flush); end
        n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd got %b%b want 0000", fwd_a, fwd_b); end
        n_checks++; if (wb_rw !== 1'b0) begin n_fail++; $display("FAIL reset_wb_reg_write got %b want 0", wb_rw); end
        rst_n = 1'b1;
        m_ex = '0; m_mem = '0; m_wb = '0;
    endtask

    task automatic test_load_use();
        drain();
        id_s = mk_lw(5'd5, 5'd2);
        tick();
        id_s = mk_alu(5'd6, 5'd5, 5'd1);
        #1;
        n_checks++; if ({pc_we, ifid_we} !== 2'b00) begin n_fail++; $display("FAIL load_use_stall got %b%b want 00", pc_we, ifid_we); end
        tick();
        n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL load_use_one_cycle got %b want 1", pc_we); end
        n_checks++; if ({ex_alu_op, ex_alu_src} !== 3'b000) begin n_fail++; $display("FAIL load_use_bubble got %b%b want 000", ex_alu_op, ex_alu_src); end
        tick();
        n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL load_use_fwd_wb got %b want 01", fwd_a); end
        n_checks++; if (ex_alu_op !== 2'b10) begin n_fail++; $display("FAIL load_use_ex_op got %b want 10", ex_alu_op); end
    endtask

    task automatic test_back_to_back();
        drain();
        id_s = mk_alu(5'd3, 5'd1, 5'd2);
        tick();
        id_s = mk_alu(5'd4, 5'd3, 5'd3);
        tick();
        n_checks++; if ({fwd_a, fwd_b} !== 4'b1010) begin n_fail++; $display("FAIL b2b_fwd_mem got %b%b want 1010", fwd_a, fwd_b); end
        drain();
        id_s = mk_alu(5'd0, 5'd1, 5'd2);
        tick();
        id_s = mk_alu(5'd4, 5'd0, 5'd0);
        tick();
        n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL b2b_fwd_x0 got %b%b want 0000", fwd_a, fwd_b); end
    endtask

    task automatic test_double_hazard();
        drain();
        id_s = mk_alu(5'd7, 5'd1, 5'd2);
        tick();
        id_s = mk_alu(5'd7, 5'd3, 5'd4);
        tick();
        id_s = mk_alu(5'd8, 5'd7, 5'd9);
        tick();
        n_checks++; if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL double_fwd_a got %b want 10", fwd_a); end
        n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL double_fwd_b got %b want 00", fwd_b); end
    endtask

    task automatic test_branch();
        drain();
        id_s = mk_beq(5'd1, 5'd2);
        tick();
        id_s = mk_alu(5'd10, 5'd1, 5'd2);
        cond = 1'b1;
        #1;
        n_checks++; if ({redirect, flush, pc_we} !== 3'b111) begin n_fail++; $display("FAIL beq_taken got %b%b%b want 111", redirect, flush, pc_we); end
        tick();
        n_checks++; if ({ex_branch, ex_alu_op, redirect} !== 4'b0000) begin n_fail++; $display("FAIL beq_ex_bubble got %b%b%b want 0000", ex_branch, ex_alu_op, redirect); end
        drain();
        id_s = mk_beq(5'd1, 5'd2);
        tick();
        id_s = mk_alu(5'd10, 5'd1, 5'd2);
        cond = 1'b0;
        #1;
        n_checks++; if ({redirect, flush} !== 2'b00) begin n_fail++; $display("FAIL beq_not_taken got %b%b want 00", redirect, flush); end
        tick();
        n_checks++; if (ex_alu_op !== 2'b10) begin n_fail++; $display("FAIL beq_not_taken_ex got %b want 10", ex_alu_op); end
    endtask

    task automatic test_redirect_vs_stall();
        slot_t j;
        drain();
        j = mk_lw(5'd5, 5'd2);
        j.jump = 1'b1;
        id_s = j;
        tick();
        id_s = mk_alu(5'd6, 5'd5, 5'd1);
        #1;
        n_checks++; if ({flush, pc_we, ifid_we} !== 3'b111) begin n_fail++; $display("FAIL redir_over_stall got %b%b%b want 111", flush, pc_we, ifid_we); end
        tick();
        n_checks++; if ({ex_jump, ex_alu_op, pc_we} !== 4'b0001) begin n_fail++; $display("FAIL redir_killed got %b%b%b want 0001", ex_jump, ex_alu_op, pc_we); end
        // Reset while a stall is being asserted.
        drain();
        id_s = mk_lw(5'd5, 5'd2);
        tick();
        id_s = mk_alu(5'd6, 5'd5, 5'd1);
        #1;
        n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL pre_reset_stall got %b want 0", pc_we); end
        rst_n = 1'b0;
        #1;
        m_ex = '0; m_mem = '0; m_wb = '0;
        n_checks++; if ({pc_we, ifid_we, flush, fwd_a, fwd_b} !== 7'b1100000) begin n_fail++; $display("FAIL async_reset got %b%b%b%b%b want 1100000", pc_we, ifid_we, flush, fwd_a, fwd_b); end
        n_checks++; if ({ex_alu_op, mem_mr, wb_rw, wb_rd} !== 9'd0) begin n_fail++; $display("FAIL async_reset_stages got %b %b %b %b want 0", ex_alu_op, mem_mr, wb_rw, wb_rd); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if ({ex_alu_op, pc_we} !== 3'b101) begin n_fail++; $display("FAIL post_reset_advance got %b%b want 101", ex_alu_op, pc_we); end
    endtask

    task automatic test_random();
        logic [21:0] act, exp;
        drain();
        for (int i = 0; i < 600; i++) begin
            id_s.valid     = ($urandom_range(0, 7) != 0);
            id_s.rs1       = 5'($urandom_range(0, 7));
            id_s.rs2       = 5'($urandom_range(0, 7));
            id_s.rd        = 5'($urandom_range(0, 7));
            id_s.branch    = ($urandom_range(0, 3) == 0);
            id_s.jump      = ($urandom_range(0, 7) == 0);
            id_s.mem_read  = ($urandom_range(0, 2) == 0);
            id_s.memto_reg = 1'($urandom);
            id_s.mem_write = 1'($urandom);
            id_s.alu_src   = 1'($urandom);
            id_s.reg_write = 1'($urandom);
            id_s.alu_op    = 2'($urandom);
            cond           = 1'($urandom);
            #1;
            exp = m_expect();
            act = {pc_we, ifid_we, flush, redirect, fwd_a, fwd_b, ex_alu_op, ex_alu_src,
                   ex_branch, ex_jump, mem_mr, mem_mw, wb_rw, wb_mtr, wb_rd};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL random_cycle %0d got %b want %b", i, act, exp);
            end
            tick();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_use();
        test_back_to_back();
        test_double_hazard();
        test_branch();
        test_redirect_vs_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
